// File: rtl/exe_div.sv
// Iterative RV32M divider for the EXE stage: radix-2 restoring, one quotient bit per cycle.
// Stalls the pipeline while busy and strobes result_valid_o for one cycle when done.
module exe_div #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [XLEN-1:0] op1_i,
   input  logic [XLEN-1:0] op2_i,
   input  logic [31:0]     inst_i,
   input  logic [4:0]      reg_waddr_i,
   input  logic            abort_i,
   output logic            stall_req_o,
   output logic [XLEN-1:0] result_o,
   output logic            result_valid_o,
   output logic [4:0]      reg_waddr_o
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       op_q;
   logic [XLEN:0]    rem_q;
   logic [XLEN-1:0]  quo_q;
   logic [XLEN-1:0]  dvs_q;
   logic             qneg_q;
   logic             rneg_q;
   logic [4:0]       wa_q;
   logic [XLEN-1:0]  result_q;
   logic             valid_q;
   logic [4:0]       waddr_q;

   logic            is_div, is_signed, is_rem;
   logic            div_zero, ovf;
   logic [XLEN-1:0] abs1, abs2, spec_res;
   logic [XLEN:0]   rem_sh, rem_d;
   logic [XLEN-1:0] quo_d, fin_q, fin_r, fin;
   logic            ge;
   logic            unused_ok;

   assign is_div    = (inst_i[6:0] == 7'b0110011) && (inst_i[31:25] == 7'b0000001) && inst_i[14];
   assign is_signed = ~inst_i[12];
   assign is_rem    = inst_i[13];

   assign abs1 = (is_signed && op1_i[XLEN-1]) ? -op1_i : op1_i;
   assign abs2 = (is_signed && op2_i[XLEN-1]) ? -op2_i : op2_i;

   assign div_zero = (op2_i == '0);
   assign ovf      = is_signed && (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
   assign spec_res = div_zero ? (is_rem ? op1_i : '1)
                              : (is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}});

   // Dividend bits shift out of the quotient register into the remainder.
   assign rem_sh = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
   assign ge     = (rem_sh >= {1'b0, dvs_q});
   assign rem_d  = ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
   assign quo_d  = {quo_q[XLEN-2:0], ge};

   assign fin_q = qneg_q ? -quo_d : quo_d;
   assign fin_r = rneg_q ? -rem_d[XLEN-1:0] : rem_d[XLEN-1:0];
   assign fin   = op_q[1] ? fin_r : fin_q;

   assign stall_req_o    = !abort_i && (((state_q == IDLE) && is_div) || (state_q == CALC));
   assign result_o       = result_q;
   assign result_valid_o = valid_q;
   assign reg_waddr_o    = waddr_q;

   assign unused_ok = ^{inst_i[24:15], inst_i[11:7], rem_q[XLEN]};

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         wa_q     <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
         waddr_q  <= '0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (is_div && !abort_i) begin
                  op_q <= inst_i[13:12];
                  wa_q <= reg_waddr_i;
                  if (div_zero || ovf) begin
                     result_q <= spec_res;
                     waddr_q  <= reg_waddr_i;
                     valid_q  <= 1'b1;
                     state_q  <= DONE;
                  end else begin
                     rem_q   <= '0;
                     quo_q   <= abs1;
                     dvs_q   <= abs2;
                     qneg_q  <= is_signed && (op1_i[XLEN-1] ^ op2_i[XLEN-1]);
                     rneg_q  <= is_signed && op1_i[XLEN-1];
                     cnt_q   <= CNT_W'(XLEN);
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               if (abort_i) begin
                  state_q <= IDLE;
               end else begin
                  rem_q <= rem_d;
                  quo_q <= quo_d;
                  cnt_q <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) begin
                     result_q <= fin;
                     waddr_q  <= wa_q;
                     valid_q  <= 1'b1;
                     state_q  <= DONE;
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exe_div.sv
// Bench for exe_div: a pipeline-like driver honours stall_req_o, a monitor checks
// each valid strobe against a queue of results from an arithmetic reference model.
module tb_exe_div;

   logic        clk = 1'b0;
   logic        rst_i = 1'b0;
   logic [31:0] op1_i = '0;
   logic [31:0] op2_i = '0;
   logic [31:0] inst_i = 32'h0000_0013;
   logic [4:0]  reg_waddr_i = '0;
   logic        abort_i = 1'b0;
   logic        stall_req_o;
   logic [31:0] result_o;
   logic        result_valid_o;
   logic [4:0]  reg_waddr_o;

   exe_div #(.XLEN(32), .CNT_W(6)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .op1_i          (op1_i),
      .op2_i          (op2_i),
      .inst_i         (inst_i),
      .reg_waddr_i    (reg_waddr_i),
      .abort_i        (abort_i),
      .stall_req_o    (stall_req_o),
      .result_o       (result_o),
      .result_valid_o (result_valid_o),
      .reg_waddr_o    (reg_waddr_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          issue;
      int          lat;
   } exp_t;

   exp_t scb[$];
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
      int sa, sb;
      logic ovf;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'b100:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
         3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110:  return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Present one instruction and keep it in EXE while the divider stalls.
   task automatic run(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd,
                      input int abort_at, input int rst_at);
      logic isd, special, s, finished;
      int   explen, hold;
      exp_t e;
      isd     = (f7 == 7'b0000001) && f3[2];
      special = isd && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      explen  = !isd ? 0 : special ? 1 : 33;
      inst_i      = {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
      op1_i       = a;
      op2_i       = b;
      reg_waddr_i = rd;
      if (isd && abort_at < 0 && rst_at < 0) begin
         e.res   = ref_model(f3, a, b);
         e.rd    = rd;
         e.issue = cyc;
         e.lat   = explen;
         scb.push_back(e);
      end
      hold     = 0;
      finished = 1'b0;
      while (!finished) begin
         if (hold == abort_at) abort_i = 1'b1;
         if (hold == rst_at) rst_i = 1'b0;
         @(negedge clk);
         s = stall_req_o;
         chk("stall_req", {31'b0, s}, {31'b0, (hold < explen) && (hold != abort_at)});
         @(posedge clk);
         #1;
         if (abort_i) begin
            abort_i  = 1'b0;
            finished = 1'b1;
         end else if (!rst_i) begin
            rst_i = 1'b1;
            chk("reset result_o", result_o, 32'h0);
            chk("reset valid", {31'b0, result_valid_o}, 32'h0);
            chk("reset waddr", {27'b0, reg_waddr_o}, 32'h0);
            finished = 1'b1;
         end else if (!s) begin
            finished = 1'b1;
         end else begin
            hold++;
            if (hold > 100) begin
               chk("stall timeout", 32'(hold), 32'(explen));
               finished = 1'b1;
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_i && result_valid_o) begin
         if (scb.size() == 0) begin
            chk("unexpected valid", 32'h1, 32'h0);
         end else begin
            exp_t e;
            e = scb.pop_front();
            chk("result_o", result_o, e.res);
            chk("reg_waddr_o", {27'b0, reg_waddr_o}, {27'b0, e.rd});
            chk("latency", 32'(cyc - e.issue), 32'(e.lat));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] a, b;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("por result_o", result_o, 32'h0);
      chk("por valid", {31'b0, result_valid_o}, 32'h0);
      chk("por waddr", {27'b0, reg_waddr_o}, 32'h0);
      chk("por stall", {31'b0, stall_req_o}, 32'h0);
      @(posedge clk);
      #1;
      rst_i = 1'b1;

      run(3'b101, 7'h01, 32'd100, 32'd7, 5'd5, -1, -1);
      run(3'b111, 7'h01, 32'd100, 32'd7, 5'd6, -1, -1);
      run(3'b100, 7'h01, 32'hFFFF_FFF9, 32'd2, 5'd7, -1, -1);
      run(3'b110, 7'h01, 32'hFFFF_FFF9, 32'd2, 5'd8, -1, -1);
      run(3'b100, 7'h01, 32'd7, 32'hFFFF_FFFE, 5'd9, -1, -1);
      run(3'b100, 7'h01, 32'd5, 32'd0, 5'd10, -1, -1);
      run(3'b111, 7'h01, 32'd5, 32'd0, 5'd11, -1, -1);
      run(3'b100, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, -1, -1);
      run(3'b110, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, -1, -1);
      run(3'b100, 7'h01, 32'd1234, 32'd5, 5'd14, 10, -1);
      run(3'b101, 7'h01, 32'd9, 32'd3, 5'd15, -1, -1);
      run(3'b100, 7'h01, 32'd4321, 32'd6, 5'd16, -1, 20);
      run(3'b101, 7'h01, 32'd100, 32'd7, 5'd17, -1, -1);
      run(3'b110, 7'h01, 32'hFFFF_FFF7, 32'd4, 5'd18, -1, -1);
      run(3'b000, 7'h01, 32'd3, 32'd4, 5'd19, -1, -1);

      for (int i = 0; i < 40; i++) begin
         f3 = 3'($urandom_range(0, 7));
         f7 = ($urandom_range(0, 9) == 0) ? 7'h00 : 7'h01;
         a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 5))
            0:       b = 32'h0;
            1:       b = 32'($urandom_range(1, 15));
            2:       b = 32'hFFFF_FFFF;
            3:       b = -32'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         run(f3, f7, a, b, 5'($urandom_range(1, 31)), -1, -1);
      end

      inst_i = 32'h0000_0013;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("scoreboard drained", 32'(scb.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/exe_div.md
Name: exe_div

Overview:
- Iterative RV32M divide unit in the EXE stage, directly downstream of the ID/EXE pipeline register; consumes its op1/op2/inst/reg_waddr outputs.
- Executes DIV, DIVU, REM and REMU with a radix-2 restoring algorithm, one quotient bit per cycle.
- Holds the pipeline through a stall request to ctrl.
- Delivers the result with a one-cycle valid strobe to the EXE result mux.

Parameters:
- XLEN, 32, operand/result width
- CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-low (reset when rst_i==0)
- op1_i  in  XLEN  dividend (rs1 value from ID/EXE)
- op2_i  in  XLEN  divisor (rs2 value from ID/EXE)
- inst_i  in  32  instruction in EXE
- reg_waddr_i  in  5  destination register of inst_i
- abort_i  in  1  cancel in-flight operation (trap/flush from ctrl)
- stall_req_o  out  1  to ctrl; holds IF..EXE while high
- result_o  out  XLEN  quotient or remainder
- result_valid_o  out  1  one-cycle strobe, result_o valid
- reg_waddr_o  out  5  destination register latched at start

Behaviour:
- Decode: is_div = opcode 7'b0110011 and funct7 7'b0000001 and funct3[2]==1.
  - funct3 100 = DIV, 101 = DIVU, 110 = REM, 111 = REMU.
  - MUL funct3 values are ignored (no start).
- Reset (rst_i==0 at a clock edge), from any state including mid-CALC:
  - state = IDLE
  - result_o = 0, result_valid_o = 0, reg_waddr_o = 0
  - counter = 0, all internal registers = 0
- stall_req_o is combinational:
  - High in IDLE when is_div is true and abort_i==0.
  - High in every CALC cycle.
  - Low in DONE and otherwise.
- IDLE, start condition (is_div and abort_i==0):
  - Latch op, reg_waddr_i, |op1| and |op2| (absolute value for signed ops, raw for unsigned).
  - Latch the quotient sign (op1[31]^op2[31], signed only) and the remainder sign (op1[31], signed only).
  - Next state: CALC, counter = XLEN.
- IDLE, special cases go straight to DONE, bypassing CALC:
  - Divisor == 0: quotient = all ones; remainder = op1.
  - Signed overflow (op1 == 32'h80000000 and op2 == all ones, DIV/REM only): quotient = 32'h80000000; remainder = 0.
- CALC, each cycle:
  - Shift {rem, quo} left by 1.
  - If the shifted rem >= divisor: subtract the divisor and set the quotient LSB.
  - Decrement the counter. When the counter reaches 1 this cycle, go to DONE next.
- DONE, single cycle:
  - result_valid_o = 1.
  - result_o = quotient (DIV/DIVU) or remainder (REM/REMU), with sign correction by two's complement negation.
  - stall_req_o = 0, so the pipeline advances on this edge. Next state: IDLE.
- Result hold: result_o and reg_waddr_o hold their last value while result_valid_o is low.
- Latency:
  - Normal: 34 cycles from the instruction reaching EXE to the valid strobe (1 start + 32 CALC + 1 DONE); stall asserted for 33 cycles.
  - Special case: 2 cycles; stall asserted for 1 cycle.
- No re-trigger: IDLE is re-entered only after DONE, and the instruction in EXE has been replaced by then.
  - Back-to-back divides are therefore handled naturally, one idle-free restart per instruction.
- abort_i, in any state:
  - Next state IDLE; no result_valid_o pulse; stall_req_o drops the same cycle.
  - abort_i together with a start condition: abort wins, no start.
- Width rules:
  - Internal remainder register is XLEN+1 bits for the compare/subtract.
  - Negation is modulo 2^XLEN.

Test Plan:
- DIVU op1=100, op2=7 -> stall high 33 cycles; result_valid_o once with result_o=14 and reg_waddr_o = latched rd; REMU same operands -> 2.
- DIV op1=-7 (0xFFFFFFF9), op2=2 -> result 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIV 7 / -2 -> 0xFFFFFFFD.
- Divide by zero:
  - DIV 5/0 -> 0xFFFFFFFF after 2 cycles, stall high 1 cycle.
  - REMU 5/0 -> 5.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0; 2-cycle latency.
- Cancel and reset mid-operation:
  - abort_i pulsed at CALC cycle 10 -> stall_req_o low the same cycle, no valid strobe; a following DIVU 9/3 gives 3 normally.
  - rst_i=0 at CALC cycle 20 -> all outputs 0 next edge.
- Back-to-back DIVU 100/7 then REM -9/4 -> two strobes 34 cycles apart, values 14 then 0xFFFFFFFF; MUL (funct3 000) -> no stall, no strobe.
